// File: rtl/gpu_pkg.sv
// Shared tile geometry and FSM state types for the GPU tile datapath.
package gpu_pkg;
   localparam int TILE_DIM     = 32;
   localparam int TILE_WORDS   = 512;
   localparam int ROW_WORDS    = 16;
   localparam int ROW_WRAP_ADJ = 60;

   typedef enum logic {I_IDLE, I_ISSUE} issue_state_t;
   typedef enum logic [1:0] {W_IDLE, W_LO, W_HI} write_state_t;
endpackage

// File: rtl/tile_read_fifo.sv
// Show-ahead dual-clock FIFO with Gray-coded pointers and asynchronous clear.
module tile_read_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256
) (
   input  logic             aclr,
   input  logic             wrclk,
   input  logic             wrreq,
   input  logic [WIDTH-1:0] data,
   output logic             wrfull,
   input  logic             rdclk,
   input  logic             rdreq,
   output logic [WIDTH-1:0] q,
   output logic             rdempty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_bin, r_wr_gray, r_rq1, r_rq2;
   logic [AW:0]      r_rd_bin, r_rd_gray, r_wq1, r_wq2;
   logic             w_wr_inc, w_rd_inc;
   logic [AW:0]      w_wr_bin_nxt, w_rd_bin_nxt;

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   assign w_wr_inc     = wrreq && !wrfull;
   assign w_rd_inc     = rdreq && !rdempty;
   assign w_wr_bin_nxt = r_wr_bin + (AW+1)'(w_wr_inc);
   assign w_rd_bin_nxt = r_rd_bin + (AW+1)'(w_rd_inc);

   // Full when the write pointer has lapped the synchronised read pointer.
   assign wrfull  = (r_wr_gray == {~r_rq2[AW:AW-1], r_rq2[AW-2:0]});
   assign rdempty = (r_rd_gray == r_wq2);
   assign q       = r_mem[r_rd_bin[AW-1:0]];

   always_ff @(posedge wrclk) begin
      if (w_wr_inc) r_mem[r_wr_bin[AW-1:0]] <= data;
   end

   always_ff @(posedge wrclk or posedge aclr) begin
      if (aclr) begin
         r_wr_bin  <= '0;
         r_wr_gray <= '0;
         r_rq1     <= '0;
         r_rq2     <= '0;
      end else begin
         r_wr_bin  <= w_wr_bin_nxt;
         r_wr_gray <= bin2gray(w_wr_bin_nxt);
         r_rq1     <= r_rd_gray;
         r_rq2     <= r_rq1;
      end
   end

   always_ff @(posedge rdclk or posedge aclr) begin
      if (aclr) begin
         r_rd_bin  <= '0;
         r_rd_gray <= '0;
         r_wq1     <= '0;
         r_wq2     <= '0;
      end else begin
         r_rd_bin  <= w_rd_bin_nxt;
         r_rd_gray <= bin2gray(w_rd_bin_nxt);
         r_wq1     <= r_wr_gray;
         r_wq2     <= r_wq1;
      end
   end
endmodule

// File: rtl/tile_reader.sv
// Streams a 32x32 tile of 16-bit pixels from the framebuffer into tile RAM
// through an Avalon-MM read master on the system clock.
module tile_reader
   import gpu_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 128,
   parameter int FIFO_DEPTH      = 256
) (
   input  logic        gpu_clk,
   input  logic        gpu_rst,
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_in,
   input  logic [15:0] stride_in,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [9:0]  ram_addr_out,
   output logic [15:0] ram_data_out,
   output logic        ram_wren,
   output logic [31:0] master_address,
   output logic        master_read,
   input  logic        master_wait_request,
   input  logic [31:0] master_readdata,
   input  logic        master_readdatavalid
);
   issue_state_t r_istate, w_istate_nxt;
   write_state_t r_wstate, w_wstate_nxt;

   logic [31:0] r_curr_addr, w_next_addr;
   logic [15:0] r_stride;
   logic [8:0]  r_word_cnt, r_outstanding;
   logic [9:0]  r_ram_addr, w_ram_addr_inc;
   logic        r_busy, r_done, r_wren;
   logic [9:0]  r_ram_addr_out;
   logic [15:0] r_ram_data;

   logic        w_fifo_aclr, w_start_ok, w_push, w_pop;
   logic        w_cmd_full, w_cmd_empty, w_cmd_pop;
   logic [31:0] w_cmd_q;
   logic        w_resp_full, w_resp_empty, w_resp_push;
   logic [31:0] w_resp_q;
   logic        w_wr_en, w_wr_hi, w_done_nxt;

   assign w_fifo_aclr    = gpu_rst | rst;
   assign w_start_ok     = start && !r_busy;
   assign w_push         = (r_istate == I_ISSUE) && !w_cmd_full
                           && (r_outstanding < 9'(MAX_OUTSTANDING));
   assign w_pop          = (r_wstate == W_HI);
   assign w_ram_addr_inc = r_ram_addr + 10'd2;
   // Last word of a row jumps to the first word of the next row.
   assign w_next_addr    = (r_word_cnt[3:0] == 4'(ROW_WORDS-1))
                           ? r_curr_addr + {16'd0, r_stride} - 32'(ROW_WRAP_ADJ)
                           : r_curr_addr + 32'd4;

   assign master_read    = !w_cmd_empty;
   assign master_address = w_cmd_q;
   assign w_cmd_pop      = master_read && !master_wait_request;
   assign w_resp_push    = master_readdatavalid && !w_resp_full;

   assign busy         = r_busy;
   assign done         = r_done;
   assign ram_wren     = r_wren;
   assign ram_addr_out = r_ram_addr_out;
   assign ram_data_out = r_ram_data;

   always_comb begin
      w_istate_nxt = r_istate;
      case (r_istate)
         I_IDLE:  if (w_start_ok) w_istate_nxt = I_ISSUE;
         I_ISSUE: if (w_push && r_word_cnt == 9'(TILE_WORDS-1)) w_istate_nxt = I_IDLE;
         default: w_istate_nxt = I_IDLE;
      endcase
   end

   always_ff @(posedge gpu_clk or posedge gpu_rst) begin
      if (gpu_rst) begin
         r_istate      <= I_IDLE;
         r_word_cnt    <= '0;
         r_outstanding <= '0;
      end else begin
         r_istate <= w_istate_nxt;
         if (w_start_ok)  r_word_cnt <= '0;
         else if (w_push) r_word_cnt <= r_word_cnt + 9'd1;
         case ({w_push, w_pop})
            2'b10:   r_outstanding <= r_outstanding + 9'd1;
            2'b01:   r_outstanding <= r_outstanding - 9'd1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   always_ff @(posedge gpu_clk) begin
      if (w_start_ok) begin
         r_curr_addr <= addr_in;
         r_stride    <= stride_in;
      end else if (w_push) begin
         r_curr_addr <= w_next_addr;
      end
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_wr_en      = 1'b0;
      w_wr_hi      = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_wstate)
         W_IDLE: if (w_start_ok) w_wstate_nxt = W_LO;
         W_LO: if (!w_resp_empty) begin
            w_wr_en      = 1'b1;
            w_wstate_nxt = W_HI;
         end
         W_HI: begin
            w_wr_en = 1'b1;
            w_wr_hi = 1'b1;
            if (w_ram_addr_inc == 10'd0) begin
               w_done_nxt   = 1'b1;
               w_wstate_nxt = W_IDLE;
            end else begin
               w_wstate_nxt = W_LO;
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge gpu_clk or posedge gpu_rst) begin
      if (gpu_rst) begin
         r_wstate       <= W_IDLE;
         r_ram_addr     <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_wren         <= 1'b0;
         r_ram_addr_out <= '0;
         r_ram_data     <= '0;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_done   <= w_done_nxt;
         r_wren   <= w_wr_en;
         if (w_start_ok)      r_busy <= 1'b1;
         else if (w_done_nxt) r_busy <= 1'b0;
         if (w_start_ok)   r_ram_addr <= '0;
         else if (w_wr_hi) r_ram_addr <= w_ram_addr_inc;
         if (w_wr_en) begin
            r_ram_addr_out <= w_wr_hi ? r_ram_addr + 10'd1 : r_ram_addr;
            r_ram_data     <= w_wr_hi ? w_resp_q[31:16] : w_resp_q[15:0];
         end
      end
   end

   tile_read_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
      .aclr    (w_fifo_aclr),
      .wrclk   (gpu_clk),
      .wrreq   (w_push),
      .data    (r_curr_addr),
      .wrfull  (w_cmd_full),
      .rdclk   (clk),
      .rdreq   (w_cmd_pop),
      .q       (w_cmd_q),
      .rdempty (w_cmd_empty)
   );

   tile_read_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
      .aclr    (w_fifo_aclr),
      .wrclk   (clk),
      .wrreq   (w_resp_push),
      .data    (master_readdata),
      .wrfull  (w_resp_full),
      .rdclk   (gpu_clk),
      .rdreq   (w_pop),
      .q       (w_resp_q),
      .rdempty (w_resp_empty)
   );
endmodule
